ph_fifo_n: RTL and testbench

//  Parasite-to-host byte FIFO for the tube's high-speed block channel, generalising the 1/2-byte register to DEPTH bytes.

---
 rtl/ph_pkg.sv | 15 +
 rtl/ph_fifo_ram.sv | 34 +++
 rtl/ph_fifo_n.sv | 173 +++++++++++++++++
 tb/tb_ph_fifo_n.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ph_pkg.sv
// ph_pkg
//  Shared definitions for the parasite-to-host byte FIFO.
//  Contents:
//   ph_state_t     block-mode FSM state {PH_FILL, PH_DRAIN}
//   PH_RESET_DATA  value shown on h_data after reset/flush and before the first pop
package ph_pkg;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_DRAIN = 1'b1
    } ph_state_t;

    localparam logic [7:0] PH_RESET_DATA = 8'hAA;

endpackage : ph_pkg

// File: rtl/ph_fifo_ram.sv
// ph_fifo_ram
//  DEPTH x WIDTH storage for ph_fifo_n. Synchronous write, asynchronous read.
//  Contents are not reset.
//  Ports:
//   clk    in   1      clock
//   we     in   1      write enable
//   waddr  in   AW     write address
//   wdata  in   WIDTH  write data
//   raddr  in   AW     read address
//   rdata  out  WIDTH  combinational read data at raddr
module ph_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : ph_fifo_ram

// File: rtl/ph_fifo_n.sv
// ph_fifo_n
//  Parasite-to-host byte FIFO for the tube's high-speed block channel.
//  The parasite writes bytes, the host reads them.
//   one_byte_mode=1: behaves as a single latch (full/available as soon as one byte is held).
//   one_byte_mode=0: block mode; status holds until a whole DEPTH-byte block has
//                    been written (FILL->DRAIN) or completely read (DRAIN->FILL).
//  Optional feature macro: PH_FIFO_STATUS_EN adds h_level, overflow and underflow.
//  Ports:
//   clk                     in   1      system clock
//   h_rst_b                 in   1      asynchronous active-low reset
//   one_byte_mode           in   1      1 = one-byte mode, 0 = block mode (applies from next cycle)
//   p_we                    in   1      parasite write strobe
//   p_data                  in   WIDTH  parasite write data
//   h_re                    in   1      host read strobe (pops on this edge)
//   h_flush                 in   1      synchronous clear, overrides p_we/h_re
//   h_data                  out  WIDTH  head byte, or last popped byte when empty
//   h_data_available        out  1      host may read
//   h_zero_bytes_available  out  1      FIFO empty
//   p_full                  out  1      parasite must not write
//   h_level                 out  CNT_W  occupancy            (PH_FIFO_STATUS_EN)
//   overflow                out  1      sticky rejected write (PH_FIFO_STATUS_EN)
//   underflow               out  1      sticky rejected read  (PH_FIFO_STATUS_EN)
//
//  Strobe handshake: p_we and h_re are single-cycle requests. A write is accepted
//  on the edge where p_we=1 and p_full=0; a read is accepted on the edge where
//  h_re=1 and h_data_available=1. Any other strobe is rejected with no state change.
//  The two permits are never both asserted with an accept of the other, so a
//  write and a read never both take effect on one edge.
module ph_fifo_n
    import ph_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    h_rst_b,
    input  logic                    one_byte_mode,
    input  logic                    p_we,
    input  logic [WIDTH-1:0]        p_data,
    input  logic                    h_re,
    input  logic                    h_flush,
    output logic [WIDTH-1:0]        h_data,
    output logic                    h_data_available,
    output logic                    h_zero_bytes_available,
    output logic                    p_full
`ifdef PH_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]  h_level,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);

    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] ram_rdata;
    logic             mode_q;
    ph_state_t        state;
    ph_state_t        state_next;
    logic             wr_ok;
    logic             rd_ok;

    // Mode is registered so a change applies from the following cycle.
    always_comb begin
        if (mode_q) begin
            p_full           = (count != '0);
            h_data_available = (count != '0);
        end else begin
            p_full           = (state == PH_DRAIN);
            h_data_available = (state == PH_DRAIN);
        end
    end

    assign h_zero_bytes_available = (count == '0);
    assign h_data                 = (count != '0) ? ram_rdata : last;

    assign wr_ok = p_we & ~p_full & ~h_flush;
    assign rd_ok = h_re & h_data_available & ~h_flush;

    always_comb begin
        count_next = count;
        if (wr_ok) begin
            count_next = count + CNT_W'(1);
        end else if (rd_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // In one-byte mode the block state shadows the occupancy, so that on
    // return to block mode a full FIFO resumes in DRAIN and anything else in FILL.
    always_comb begin
        state_next = state;
        if (mode_q) begin
            state_next = (count_next == CNT_W'(DEPTH)) ? PH_DRAIN : PH_FILL;
        end else begin
            case (state)
                PH_FILL:  if (count_next == CNT_W'(DEPTH)) state_next = PH_DRAIN;
                PH_DRAIN: if (count_next == '0)            state_next = PH_FILL;
                default:                                    state_next = PH_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            mode_q <= 1'b0;
            state  <= PH_FILL;
            count  <= '0;
            wp     <= '0;
            rp     <= '0;
            last   <= WIDTH'(PH_RESET_DATA);
        end else begin
            mode_q <= one_byte_mode;
            if (h_flush) begin
                state <= PH_FILL;
                count <= '0;
                wp    <= '0;
                rp    <= '0;
                last  <= WIDTH'(PH_RESET_DATA);
            end else begin
                state <= state_next;
                count <= count_next;
                if (wr_ok) begin
                    wp <= wp + AW'(1);
                end
                if (rd_ok) begin
                    rp   <= rp + AW'(1);
                    last <= ram_rdata;
                end
            end
        end
    end

`ifdef PH_FIFO_STATUS_EN
    assign h_level = count;

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (h_flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (p_we && p_full) begin
                overflow <= 1'b1;
            end
            if (h_re && !h_data_available) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    ph_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wp),
        .wdata (p_data),
        .raddr (rp),
        .rdata (ram_rdata)
    );

endmodule : ph_fifo_n

// File: tb/tb_ph_fifo_n.sv
// tb_ph_fifo_n
//  Directed bench for ph_fifo_n (WIDTH=8, DEPTH=4). Inputs change 1 ns after
//  the rising edge; outputs are sampled at the same point.
module tb_ph_fifo_n;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             h_rst_b;
    logic             one_byte_mode;
    logic             p_we;
    logic [WIDTH-1:0] p_data;
    logic             h_re;
    logic             h_flush;
    logic [WIDTH-1:0] h_data;
    logic             h_data_available;
    logic             h_zero_bytes_available;
    logic             p_full;
`ifdef PH_FIFO_STATUS_EN
    logic [CNT_W-1:0] h_level;
    logic             overflow;
    logic             underflow;
`endif

    int n_vec;
    int n_err;
    logic [WIDTH-1:0] exp_q[$];

    ph_fifo_n #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk                    (clk),
        .h_rst_b                (h_rst_b),
        .one_byte_mode          (one_byte_mode),
        .p_we                   (p_we),
        .p_data                 (p_data),
        .h_re                   (h_re),
        .h_flush                (h_flush),
        .h_data                 (h_data),
        .h_data_available       (h_data_available),
        .h_zero_bytes_available (h_zero_bytes_available),
        .p_full                 (p_full)
`ifdef PH_FIFO_STATUS_EN
        ,
        .h_level                (h_level),
        .overflow               (overflow),
        .underflow              (underflow)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [WIDTH-1:0] d);
        p_we   = 1'b1;
        p_data = d;
        tick();
        p_we   = 1'b0;
    endtask

    task automatic do_read();
        h_re = 1'b1;
        tick();
        h_re = 1'b0;
    endtask

    task automatic do_flush();
        h_flush = 1'b1;
        tick();
        h_flush = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic avail, input logic full,
                             input logic zero);
        chk({tag, "_avail"}, 32'(h_data_available), 32'(avail));
        chk({tag, "_full"},  32'(p_full),           32'(full));
        chk({tag, "_zero"},  32'(h_zero_bytes_available), 32'(zero));
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        h_rst_b       = 1'b0;
        one_byte_mode = 1'b0;
        p_we          = 1'b0;
        p_data        = '0;
        h_re          = 1'b0;
        h_flush       = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_hdata", 32'(h_data), 32'h0000_00AA);
        chk_flags("rst", 1'b0, 1'b0, 1'b1);
`ifdef PH_FIFO_STATUS_EN
        chk("rst_level", 32'(h_level), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_udf",   32'(underflow), 32'd0);
`endif
        h_rst_b = 1'b1;
        tick();

        // one-byte mode: single latch
        one_byte_mode = 1'b1;
        tick();
        do_write(8'h11);
        chk_flags("ob_w1", 1'b1, 1'b1, 1'b0);
        chk("ob_w1_hdata", 32'(h_data), 32'h11);
        do_write(8'h22);
        chk("ob_rej_hdata", 32'(h_data), 32'h11);
        chk_flags("ob_rej", 1'b1, 1'b1, 1'b0);
`ifdef PH_FIFO_STATUS_EN
        chk("ob_rej_ovf", 32'(overflow), 32'd1);
`endif
        do_read();
        chk("ob_rd_hdata", 32'(h_data), 32'h11);
        chk_flags("ob_rd", 1'b0, 1'b0, 1'b1);
        do_flush();
        chk("flush_hdata", 32'(h_data), 32'h0000_00AA);
`ifdef PH_FIFO_STATUS_EN
        chk("flush_ovf", 32'(overflow), 32'd0);
`endif

        // one-byte mode: write and read in the same cycle at count 1
        do_write(8'h33);
        p_we   = 1'b1;
        p_data = 8'h44;
        h_re   = 1'b1;
        tick();
        p_we   = 1'b0;
        h_re   = 1'b0;
        chk_flags("sim", 1'b0, 1'b0, 1'b1);
        chk("sim_hdata", 32'(h_data), 32'h33);
`ifdef PH_FIFO_STATUS_EN
        chk("sim_ovf", 32'(overflow), 32'd1);
        chk("sim_level", 32'(h_level), 32'd0);
`endif

        // block mode basic
        do_flush();
        one_byte_mode = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            do_write(WIDTH'(i));
            chk_flags($sformatf("blk_w%0d", i), 1'b0, 1'b0, 1'b0);
        end
        do_write(8'h04);
        chk_flags("blk_w4", 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("blk_head%0d", i), 32'(h_data), 32'(i));
            do_read();
            chk($sformatf("blk_r%0d_full", i), 32'(p_full), (i == 4) ? 32'd0 : 32'd1);
        end
        chk("blk_end_hdata", 32'(h_data), 32'h04);
        chk_flags("blk_end", 1'b0, 1'b0, 1'b1);
        do_read();
        chk("udf_hdata", 32'(h_data), 32'h04);
`ifdef PH_FIFO_STATUS_EN
        chk("udf_flag", 32'(underflow), 32'd1);
`endif

        // three blocks through the pointer wrap, scoreboard ordered
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(WIDTH'(b * 4 + i));
                do_write(WIDTH'(b * 4 + i));
`ifdef PH_FIFO_STATUS_EN
                chk($sformatf("wrap_lvl_w%0d", b * 4 + i), 32'(h_level), 32'(i + 1));
`endif
            end
            chk($sformatf("wrap_avail%0d", b), 32'(h_data_available), 32'd1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("wrap_data%0d", b * 4 + i), 32'(h_data), 32'(exp_q.pop_front()));
                do_read();
`ifdef PH_FIFO_STATUS_EN
                chk($sformatf("wrap_lvl_r%0d", b * 4 + i), 32'(h_level), 32'(3 - i));
`endif
            end
        end
        chk("wrap_empty", 32'(h_zero_bytes_available), 32'd1);

        // mode switch with a partial block
        do_write(8'hAB);
        do_write(8'hCD);
        chk_flags("ms_blk2", 1'b0, 1'b0, 1'b0);
        one_byte_mode = 1'b1;
        tick();
        chk_flags("ms_ob", 1'b1, 1'b1, 1'b0);
        chk("ms_ob_hdata", 32'(h_data), 32'hAB);
        one_byte_mode = 1'b0;
        tick();
        chk_flags("ms_back_fill", 1'b0, 1'b0, 1'b0);
        do_write(8'hEF);
        do_write(8'h5A);
        chk_flags("ms_drain", 1'b1, 1'b1, 1'b0);
        one_byte_mode = 1'b1;
        tick();
        one_byte_mode = 1'b0;
        tick();
        chk_flags("ms_back_drain", 1'b1, 1'b1, 1'b0);
        chk("ms_back_hdata", 32'(h_data), 32'hAB);
        do_flush();
        chk_flags("ms_flush", 1'b0, 1'b0, 1'b1);
        chk("ms_flush_hdata", 32'(h_data), 32'h0000_00AA);

        // reset while in DRAIN
        for (int i = 0; i < 4; i++) begin
            do_write(WIDTH'(8'hC0 + i));
        end
        chk_flags("pre_rst_drain", 1'b1, 1'b1, 1'b0);
        h_rst_b = 1'b0;
        tick();
        chk_flags("rst_drain", 1'b0, 1'b0, 1'b1);
        chk("rst_drain_hdata", 32'(h_data), 32'h0000_00AA);
        h_rst_b = 1'b1;
        tick();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ph_fifo_n
